// File: rtl/counter_fractional_bank.sv
`default_nettype none
// ============================================================================
// Module   : counter_fractional_bank
// Brief    : Bank of phase-accumulator tick generators with wrap-synchronous
//            runtime reprogramming, per-channel phase sync and config checking.
// Revision : 1.0
// ============================================================================
module counter_fractional_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int ADD_RST  = 1,
    parameter int MAX_RST  = 2,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ena,
    input  logic [CHANNELS-1:0]       sync,
    input  logic                      cfg_vld,
    output logic                      cfg_rdy,
    input  logic [CW-1:0]             cfg_chn,
    input  logic [WIDTH-1:0]          cfg_add,
    input  logic [WIDTH-1:0]          cfg_max,
    output logic                      cfg_err,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       pls
);

    localparam int c_NPAD = 1 << CW;

    logic [CHANNELS-1:0] w_pend;
    logic [c_NPAD-1:0]   w_pend_ext;
    logic                w_chn_ok;
    logic                w_xfer;
    logic                w_legal;
    logic                r_err;

    // Out-of-range channels read as "not pending" so the request transfers and is rejected.
    assign w_pend_ext = c_NPAD'(w_pend);
    assign cfg_rdy    = ~w_pend_ext[cfg_chn];
    assign w_chn_ok   = (32'(cfg_chn) < CHANNELS);
    assign w_xfer     = cfg_vld & cfg_rdy;
    assign w_legal    = w_chn_ok && (cfg_max != '0) && (cfg_add < cfg_max);
    assign cfg_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_legal;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] r_cnt;
            logic             r_pls;
            logic [WIDTH-1:0] r_add;
            logic [WIDTH-1:0] r_max;
            logic [WIDTH-1:0] r_sh_add;
            logic [WIDTH-1:0] r_sh_max;
            logic             r_pend;
            logic [WIDTH:0]   w_nxt;
            logic [WIDTH:0]   w_rem;
            logic             w_wrp;
            logic             w_apply;
            logic             w_load;
            logic             w_clamp;

            assign w_nxt   = {1'b0, r_cnt} + {1'b0, r_add};
            assign w_wrp   = (w_nxt >= {1'b0, r_max});
            assign w_rem   = w_nxt - {1'b0, r_max};
            assign w_apply = r_pend & (sync[i] | ~ena[i] | w_wrp);
            assign w_load  = w_xfer & w_legal & (cfg_chn == CW'(i));
            // A shrinking maximum may leave the remainder out of range for the new config.
            assign w_clamp = w_apply & (w_rem >= {1'b0, r_sh_max});

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_pls    <= 1'b0;
                    r_add    <= WIDTH'(ADD_RST);
                    r_max    <= WIDTH'(MAX_RST);
                    r_sh_add <= '0;
                    r_sh_max <= '0;
                    r_pend   <= 1'b0;
                end else begin
                    if (sync[i]) begin
                        r_cnt <= '0;
                        r_pls <= 1'b0;
                    end else if (ena[i]) begin
                        r_pls <= w_wrp;
                        if (w_wrp) begin
                            r_cnt <= w_clamp ? '0 : w_rem[WIDTH-1:0];
                        end else begin
                            r_cnt <= w_nxt[WIDTH-1:0];
                        end
                    end else begin
                        r_pls <= 1'b0;
                    end

                    if (w_apply) begin
                        r_add  <= r_sh_add;
                        r_max  <= r_sh_max;
                        r_pend <= 1'b0;
                    end else if (w_load) begin
                        r_sh_add <= cfg_add;
                        r_sh_max <= cfg_max;
                        r_pend   <= 1'b1;
                    end
                end
            end

            assign cnt[i*WIDTH +: WIDTH] = r_cnt;
            assign pls[i]                = r_pls;
            assign w_pend[i]             = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire
